mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 8K x 8 byte memory.
- Port A is instruction fetch (read-only); port B is data access (read/write).
- Drives the memory's memRead, memWrite, addressMem and dataMem; captures memOut into per-port read-data registers; answers each requester with a one-cycle ack.
- Sits between the fetch/datapath logic and the Memory instance.

Parameters:
ADDR_W, 13, address width (matches memory depth 8192)
DATA_W, 8, data word width
WAIT_CYCLES, 0, extra ACCESS cycles inserted per transaction (0..7)

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
a_req  input  1  port A read request, held until a_ack
a_addr  input  ADDR_W  port A address, stable while a_req
a_ack  output  1  one-cycle completion pulse for port A
a_rdata  output  DATA_W  port A read data, valid with a_ack, held until next a_ack
b_req  input  1  port B request, held until b_ack
b_we  input  1  port B: 1 = write, 0 = read; stable while b_req
b_addr  input  ADDR_W  port B address
b_wdata  input  DATA_W  port B write data
b_ack  output  1  one-cycle completion pulse for port B
b_rdata  output  DATA_W  port B read data, valid with b_ack on reads, held until next b_ack read
busy  output  1  high in any state other than IDLE
memRead  output  1  to memory read enable
memWrite  output  1  to memory write enable
addressMem  output  ADDR_W  to memory address
dataMem  output  DATA_W  to memory write data
memOut  input  DATA_W  from memory, combinational read data

Behaviour:
- Reset (reset_n low at a rising edge) sets, on that edge:
  - state = IDLE, last_grant = B, wait counter = 0.
  - a_ack = b_ack = 0, busy = 0, memRead = memWrite = 0.
  - addressMem = 0, dataMem = 0, a_rdata = b_rdata = 0.
- All outputs are registered.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port not equal to last_grant (round-robin; after reset port A wins first).
  - On grant: latch port id, addressMem <= granted addr; for port B also dataMem <= b_wdata and latch we.
  - Set memRead <= !we (port A is always a read); load wait counter with WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - addressMem, dataMem and memRead are held constant.
  - Counter > 0: decrement it, stay in ACCESS.
  - Counter == 0, read: capture memOut into the granted port's rdata; memRead <= 0.
  - Counter == 0, write: memWrite is high for exactly this final ACCESS cycle, so the memory commits on the edge leaving ACCESS; memWrite <= 0.
  - Counter == 0, either case: update last_grant, assert the granted ack, go to ACK.
- ACK:
  - Granted ack is high for this single cycle; next edge clears it and returns to IDLE.
  - A req still high in IDLE is treated as a new transaction.
  - Requesters must drop req in the cycle after ack to avoid a repeat access.
- Latency and throughput:
  - req sampled at edge k -> ack high in cycle k+2+WAIT_CYCLES.
  - One transaction per 3+WAIT_CYCLES cycles.
- Only one port is granted at a time. a_ack and b_ack are never high in the same cycle.
- Requests that arrive or change during ACCESS/ACK are ignored until IDLE.
- memRead and memWrite are never high together; both are 0 outside ACCESS.
- addressMem and dataMem hold their last values outside ACCESS.
- Write transactions leave b_rdata unchanged.
- Reset mid-transaction: the operation is abandoned and no ack is issued. memWrite is 0 after the reset edge. If reset hits the final ACCESS cycle of a write, that edge is a reset edge, so memWrite is sampled high by the memory at that same edge and the write may commit. This is acceptable.
- Address wrap: none; addresses pass through unmodified over the full 0..8191 range.

Test Plan:
- After reset: A reads 0x0005 holding 0x3C -> a_ack pulses 2 cycles after req sampled (WAIT_CYCLES=0), a_rdata = 0x3C held afterwards, memRead high exactly 1 cycle.
- B writes 0xA5 to 0x1FFF, then B reads 0x1FFF -> memWrite high 1 cycle with addressMem = 0x1FFF, dataMem = 0xA5; the read returns b_rdata = 0xA5; b_rdata unchanged by the write's ack.
- a_req and b_req both rise in the same cycle right after reset -> A served first, then B; with both held continuously, grants alternate A, B, A, B; acks never overlap.
- WAIT_CYCLES=3: A read -> ACCESS lasts 4 cycles with addressMem stable; ack at cycle k+5; memOut is sampled only in the last ACCESS cycle.
- reset_n driven low during ACCESS of a B read -> no b_ack, busy = 0 and memRead = 0 after the edge, state IDLE; a fresh a_req is then granted normally.
- Requester holds req one cycle past ack -> a second access is issued; verify count and round-robin against the other port.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared 8K x 8 byte memory.
// Port A: instruction fetch (read-only). Port B: data read/write.
// Round-robin between simultaneous requesters, registered memory controls,
// per-port read-data capture and a one-cycle ack per transaction.
module mem_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] addressMem,
  output logic [DATA_W-1:0] dataMem,
  input  logic [DATA_W-1:0] memOut
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACK
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t            state_q, state_d;
  port_t             last_grant_q, last_grant_d;
  port_t             gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              busy_q, busy_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pick_b;

  // Next-state and registered-output computation for the IDLE/ACCESS/ACK sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    pick_b       = b_req && (!a_req || (last_grant_q == PORT_A));

    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          gnt_d      = pick_b ? PORT_B : PORT_A;
          we_d       = pick_b && b_we;
          addr_d     = pick_b ? b_addr : a_addr;
          if (pick_b) begin
            data_d = b_wdata;
          end
          mem_read_d = !(pick_b && b_we);
          // memWrite is registered, so it must rise on the edge that enters
          // the final ACCESS cycle; with no wait states that is this edge.
          mem_write_d = pick_b && b_we && (WAIT_LOAD == 3'd0);
          cnt_d      = WAIT_LOAD;
          state_d    = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
          if ((cnt_q == 3'd1) && we_q) begin
            mem_write_d = 1'b1;
          end
        end else begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) begin
            if (gnt_q == PORT_A) begin
              a_rdata_d = memOut;
            end else begin
              b_rdata_d = memOut;
            end
          end
          last_grant_d = gnt_q;
          a_ack_d      = (gnt_q == PORT_A);
          b_ack_d      = (gnt_q == PORT_B);
          state_d      = ST_ACK;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_B;
      gnt_q        <= PORT_A;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      busy_q       <= busy_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign busy       = busy_q;
  assign memRead    = mem_read_q;
  assign memWrite   = mem_write_q;
  assign addressMem = addr_q;
  assign dataMem    = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a zero-wait instance and a
// three-wait instance, each attached to its own behavioural byte memory.
module tb_mem_arbiter;

  logic        clock;
  logic        reset_n;

  // zero-wait instance
  logic        a_req, a_ack, b_req, b_we, b_ack, busy, memRead, memWrite;
  logic [12:0] a_addr, b_addr, addressMem;
  logic [7:0]  a_rdata, b_wdata, b_rdata, dataMem, memOut;

  // three-wait instance
  logic        a3_req, a3_ack, b3_req, b3_we, b3_ack, busy3, memRead3, memWrite3;
  logic [12:0] a3_addr, b3_addr, addr3;
  logic [7:0]  a3_rdata, b3_wdata, b3_rdata, data3, memOut3;
  logic        corrupt3;

  logic [7:0]  mem0    [8192];
  logic [7:0]  mem3    [8192];
  logic [7:0]  ref_mem [8192];

  int          n_cmp;
  int          n_err;
  logic        mon_en;
  int          last_m;   // 0 = A, 1 = B : model of round-robin history
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;

  mem_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(0)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .busy(busy),
    .memRead(memRead), .memWrite(memWrite), .addressMem(addressMem),
    .dataMem(dataMem), .memOut(memOut)
  );

  mem_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .a_req(a3_req), .a_addr(a3_addr), .a_ack(a3_ack), .a_rdata(a3_rdata),
    .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
    .b_ack(b3_ack), .b_rdata(b3_rdata), .busy(busy3),
    .memRead(memRead3), .memWrite(memWrite3), .addressMem(addr3),
    .dataMem(data3), .memOut(memOut3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural memories: combinational read, write committed at the clock edge
  assign memOut  = mem0[addressMem];
  assign memOut3 = corrupt3 ? ~mem3[addr3] : mem3[addr3];

  always @(posedge clock) if (memWrite)  mem0[addressMem] <= dataMem;
  always @(posedge clock) if (memWrite3) mem3[addr3]      <= data3;

  // continuous exclusivity monitor
  always @(negedge clock) begin
    if (mon_en && reset_n) begin
      n_cmp++;
      if ((memRead === 1'b1 && memWrite === 1'b1) || (a_ack === 1'b1 && b_ack === 1'b1)) begin
        n_err++;
        $display("FAIL exclusive: memRead=%b memWrite=%b a_ack=%b b_ack=%b required no overlap",
                 memRead, memWrite, a_ack, b_ack);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    last_m  = 1;
    exp_a   = 8'h00;
    exp_b   = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({a_ack, b_ack, busy, memRead, memWrite} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 00000", {a_ack, b_ack, busy, memRead, memWrite});
    end
    n_cmp++;
    if (addressMem !== 13'h0 || dataMem !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mem_bus: addr=%h data=%h required 0/0", addressMem, dataMem);
    end
    n_cmp++;
    if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rdata: a=%h b=%h required 00/00", a_rdata, b_rdata);
    end
    n_cmp++;
    if ({a3_ack, b3_ack, busy3, memRead3, memWrite3, addr3, data3, a3_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_dut3: ack=%b busy=%b rd=%b wr=%b addr=%h required all zero",
               {a3_ack, b3_ack}, busy3, memRead3, memWrite3, addr3);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    int reads;
    reads = 0;
    mem0[13'h0005]    = 8'h3C;
    ref_mem[13'h0005] = 8'h3C;
    @(negedge clock);
    a_addr = 13'h0005;
    a_req  = 1'b1;
    tick();
    if (memRead) reads++;
    n_cmp++;
    if (a_ack !== 1'b0 || busy !== 1'b1 || addressMem !== 13'h0005) begin
      n_err++;
      $display("FAIL read_access: ack=%b busy=%b addr=%h required 0/1/0005", a_ack, busy, addressMem);
    end
    tick();
    if (memRead) reads++;
    n_cmp++;
    if (a_ack !== 1'b1 || a_rdata !== 8'h3C) begin
      n_err++;
      $display("FAIL read_ack: ack=%b rdata=%h required 1/3c", a_ack, a_rdata);
    end
    a_req = 1'b0;
    exp_a = 8'h3C;
    last_m = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (memRead) reads++;
    end
    n_cmp++;
    if (a_ack !== 1'b0 || busy !== 1'b0 || a_rdata !== exp_a) begin
      n_err++;
      $display("FAIL read_hold: ack=%b busy=%b rdata=%h required 0/0/%h", a_ack, busy, a_rdata, exp_a);
    end
    n_cmp++;
    if (reads != 1) begin
      n_err++;
      $display("FAIL read_memread_len: got %0d cycles required 1", reads);
    end
  endtask

  task automatic test_write_read();
    @(negedge clock);
    b_addr  = 13'h1FFF;
    b_wdata = 8'hA5;
    b_we    = 1'b1;
    b_req   = 1'b1;
    tick();
    n_cmp++;
    if (memWrite !== 1'b1 || memRead !== 1'b0 || addressMem !== 13'h1FFF || dataMem !== 8'hA5) begin
      n_err++;
      $display("FAIL write_bus: wr=%b rd=%b addr=%h data=%h required 1/0/1fff/a5",
               memWrite, memRead, addressMem, dataMem);
    end
    tick();
    n_cmp++;
    if (b_ack !== 1'b1 || memWrite !== 1'b0 || b_rdata !== exp_b) begin
      n_err++;
      $display("FAIL write_ack: ack=%b wr=%b b_rdata=%h required 1/0/%h", b_ack, memWrite, b_rdata, exp_b);
    end
    b_req = 1'b0;
    ref_mem[13'h1FFF] = 8'hA5;
    last_m = 1;
    tick();
    n_cmp++;
    if (mem0[13'h1FFF] !== ref_mem[13'h1FFF]) begin
      n_err++;
      $display("FAIL write_commit: mem=%h required %h", mem0[13'h1FFF], ref_mem[13'h1FFF]);
    end
    @(negedge clock);
    b_we  = 1'b0;
    b_req = 1'b1;
    tick();
    tick();
    exp_b = ref_mem[13'h1FFF];
    n_cmp++;
    if (b_ack !== 1'b1 || b_rdata !== exp_b) begin
      n_err++;
      $display("FAIL readback: ack=%b b_rdata=%h required 1/%h", b_ack, b_rdata, exp_b);
    end
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int acks;
    int exp_port;
    do_reset();
    @(negedge clock);
    a_addr = 13'h0100;
    b_addr = 13'h0200;
    b_we   = 1'b0;
    a_req  = 1'b1;
    b_req  = 1'b1;
    acks   = 0;
    exp_port = 0;
    for (int c = 0; c < 20 && acks < 4; c++) begin
      tick();
      if (a_ack || b_ack) begin
        n_cmp++;
        if ((a_ack ? 0 : 1) != exp_port || c != 1 + 3 * acks) begin
          n_err++;
          $display("FAIL rr_order: ack%0d port=%0d cycle=%0d required port=%0d cycle=%0d",
                   acks, a_ack ? 0 : 1, c, exp_port, 1 + 3 * acks);
        end
        if (a_ack) exp_a = ref_mem[a_addr];
        else       exp_b = ref_mem[b_addr];
        n_cmp++;
        if (a_rdata !== exp_a || b_rdata !== exp_b) begin
          n_err++;
          $display("FAIL rr_data: a=%h b=%h required %h/%h", a_rdata, b_rdata, exp_a, exp_b);
        end
        last_m   = exp_port;
        exp_port = 1 - exp_port;
        acks++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    n_cmp++;
    if (acks != 4) begin
      n_err++;
      $display("FAIL rr_count: got %0d acks required 4", acks);
    end
    tick();
  endtask

  task automatic test_wait3();
    int reads;
    reads = 0;
    mem3[13'h0ABC] = 8'h5E;
    @(negedge clock);
    a3_addr  = 13'h0ABC;
    a3_req   = 1'b1;
    corrupt3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) corrupt3 = 1'b0;   // only the last ACCESS cycle sees true data
      if (memRead3) reads++;
      n_cmp++;
      if (addr3 !== 13'h0ABC || a3_ack !== 1'b0 || busy3 !== 1'b1) begin
        n_err++;
        $display("FAIL wait_access%0d: addr=%h ack=%b busy=%b required 0abc/0/1", i, addr3, a3_ack, busy3);
      end
    end
    tick();
    n_cmp++;
    if (a3_ack !== 1'b1 || a3_rdata !== 8'h5E || memRead3 !== 1'b0) begin
      n_err++;
      $display("FAIL wait_ack: ack=%b rdata=%h rd=%b required 1/5e/0", a3_ack, a3_rdata, memRead3);
    end
    a3_req = 1'b0;
    tick();
    n_cmp++;
    if (a3_ack !== 1'b0 || busy3 !== 1'b0 || reads != 4) begin
      n_err++;
      $display("FAIL wait_done: ack=%b busy=%b reads=%0d required 0/0/4", a3_ack, busy3, reads);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int ack_at;
    @(negedge clock);
    b_addr = 13'h0777;
    b_we   = 1'b0;
    b_req  = 1'b1;
    tick();
    n_cmp++;
    if (memRead !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: memRead=%b required 1", memRead);
    end
    reset_n = 1'b0;
    b_req   = 1'b0;
    tick();
    n_cmp++;
    if (b_ack !== 1'b0 || busy !== 1'b0 || memRead !== 1'b0 || memWrite !== 1'b0 || b_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset: ack=%b busy=%b rd=%b wr=%b b_rdata=%h required 0/0/0/0/00",
               b_ack, busy, memRead, memWrite, b_rdata);
    end
    reset_n = 1'b1;
    last_m  = 1;
    exp_a   = 8'h00;
    exp_b   = 8'h00;
    seen    = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (b_ack) seen++;
    end
    n_cmp++;
    if (seen != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_no_ack: b_acks=%0d busy=%b required 0/0", seen, busy);
    end
    @(negedge clock);
    a_addr = 13'h0042;
    a_req  = 1'b1;
    ack_at = -1;
    for (int c = 0; c < 8 && ack_at < 0; c++) begin
      tick();
      if (a_ack) ack_at = c;
    end
    a_req = 1'b0;
    exp_a = ref_mem[13'h0042];
    last_m = 0;
    n_cmp++;
    if (ack_at != 1 || a_rdata !== exp_a) begin
      n_err++;
      $display("FAIL mid_fresh: ack_cycle=%0d rdata=%h required 1/%h", ack_at, a_rdata, exp_a);
    end
    tick();
  endtask

  task automatic test_hold_past_ack();
    int acks_a;
    int acks_b;
    int pos [2];
    int got;
    @(negedge clock);
    a_addr = 13'h0333;
    a_req  = 1'b1;
    acks_a = 0;
    acks_b = 0;
    pos[0] = -1;
    pos[1] = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (a_ack) begin
        if (acks_a < 2) pos[acks_a] = c;
        acks_a++;
      end
      if (b_ack) acks_b++;
      if (c == 3) a_req = 1'b0;   // held through the IDLE cycle after the ack
    end
    exp_a  = ref_mem[13'h0333];
    last_m = 0;
    n_cmp++;
    if (acks_a != 2 || acks_b != 0 || pos[0] != 1 || pos[1] != 4) begin
      n_err++;
      $display("FAIL hold_repeat: a_acks=%0d b_acks=%0d at %0d,%0d required 2/0 at 1,4",
               acks_a, acks_b, pos[0], pos[1]);
    end
    @(negedge clock);
    a_addr = 13'h0011;
    b_addr = 13'h1000;
    b_we   = 1'b0;
    a_req  = 1'b1;
    b_req  = 1'b1;
    for (int n = 0; n < 2; n++) begin
      got = -1;
      for (int c = 0; c < 8 && got < 0; c++) begin
        tick();
        if (a_ack) got = 0;
        else if (b_ack) got = 1;
      end
      if (got == 0) begin a_req = 1'b0; exp_a = ref_mem[13'h0011]; end
      if (got == 1) begin b_req = 1'b0; exp_b = ref_mem[13'h1000]; end
      n_cmp++;
      if (got != 1 - n || a_rdata !== exp_a || b_rdata !== exp_b) begin
        n_err++;
        $display("FAIL hold_rr%0d: port=%0d a=%h b=%h required port=%0d a=%h b=%h",
                 n, got, a_rdata, b_rdata, 1 - n, exp_a, exp_b);
      end
    end
    a_req  = 1'b0;
    b_req  = 1'b0;
    last_m = 0;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int unsigned mode;
      logic [12:0] aa;
      logic [12:0] ba;
      logic        bw;
      logic [7:0]  bd;
      int          exp_q [$];
      int          got;
      mode = $urandom_range(0, 2);
      aa   = 13'($urandom);
      ba   = (it % 4 == 0) ? aa : 13'($urandom);
      bw   = 1'($urandom);
      bd   = 8'($urandom);
      exp_q = {};
      if (mode == 0)      exp_q.push_back(0);
      else if (mode == 1) exp_q.push_back(1);
      else if (last_m == 1) begin exp_q.push_back(0); exp_q.push_back(1); end
      else                  begin exp_q.push_back(1); exp_q.push_back(0); end
      @(negedge clock);
      a_addr  = aa;
      b_addr  = ba;
      b_we    = bw;
      b_wdata = bd;
      a_req   = (mode != 1);
      b_req   = (mode != 0);
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
        tick();
        if (a_ack || b_ack) begin
          got = a_ack ? 0 : 1;
          n_cmp++;
          if (got != exp_q[0]) begin
            n_err++;
            $display("FAIL rand_order it%0d: port=%0d required %0d", it, got, exp_q[0]);
          end
          if (a_ack) begin
            exp_a = ref_mem[aa];
            a_req = 1'b0;
          end else begin
            if (bw) ref_mem[ba] = bd;
            else    exp_b = ref_mem[ba];
            b_req = 1'b0;
          end
          n_cmp++;
          if (a_rdata !== exp_a || b_rdata !== exp_b) begin
            n_err++;
            $display("FAIL rand_data it%0d: a=%h b=%h required %h/%h", it, a_rdata, b_rdata, exp_a, exp_b);
          end
          last_m = got;
          void'(exp_q.pop_front());
        end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL rand_timeout it%0d: %0d acks outstanding required 0", it, exp_q.size());
      end
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    a3_req = 1'b0; a3_addr = '0; b3_req = 1'b0; b3_we = 1'b0; b3_addr = '0; b3_wdata = '0;
    corrupt3 = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      ref_mem[i] = 8'($urandom);
      mem0[i]    = ref_mem[i];
      mem3[i]    = 8'($urandom);
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_wait3();
    test_reset_mid();
    test_hold_past_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
